// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has priority, debug port gets a bounded wait.
// Read data returns one cycle after the grant and is steered to the issuing port.
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pending_q, rd_pending_d;
  logic       rd_owner_q, rd_owner_d;
  logic       cpu_win, dbg_win;

  // Debug only overrides the CPU once it has lost MAX_WAIT contested cycles in a row.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      if (cpu_req && dbg_req) begin
        if (wait_cnt_q == MaxWait) dbg_win = 1'b1;
        else                       cpu_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_win | dbg_win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  always_comb begin
    wait_cnt_d = '0;
    if (!rst && dbg_req && !dbg_win) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  assign rd_pending_d = mem_en & ~mem_we;
  assign rd_owner_d   = dbg_win;

  // A read granted just before reset still answers in the first reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign cpu_rvalid = rd_pending_q & ~rd_owner_q;
  assign dbg_rvalid = rd_pending_q &  rd_owner_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read 32 x 16 memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: reset loads mem[i] = i; read data is registered.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [4:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [4:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 16'hAAAA, 1'b1, 1'b0, 5'd4, 16'h0);
    // Reset with both ports requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      drive(1'b1, 1'b1, 5'd9, 16'hAAAA, 1'b1, 1'b0, 5'd4, 16'h0);
      check_val("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check_val("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      check_val("rst_mem_en", 32'(mem_en), 32'd0);
      check_val("rst_mem_we", 32'(mem_we), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check_val("rst_rvalids", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      check_val("rst_rdatas", 32'({cpu_rdata, dbg_rdata}), 32'd0);
      $display("txn reset cycle %0d: gnt=%b%b mem_en=%b", c, cpu_gnt, dbg_gnt, mem_en);
    end
    rst = 1'b0;
    tick();
    drive(1'b1, 1'b1, 5'd9, 16'hAAAA, 1'b1, 1'b0, 5'd4, 16'h0);
    check_val("post_rst_rvalids", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check_val("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_val("post_rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    $display("txn first post-reset cycle: cpu_gnt=%b dbg_gnt=%b", cpu_gnt, dbg_gnt);

    // CPU write 0x1234 to 5, then read 5.
    tick();
    drive(1'b1, 1'b1, 5'd5, 16'h1234, 1'b0, 1'b0, 5'd0, 16'h0);
    check_val("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_val("wr_mem_we", 32'(mem_we), 32'd1);
    check_val("wr_mem_addr", 32'(mem_addr), 32'd5);
    check_val("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    check_val("wr_after_write_rvalid", 32'(cpu_rvalid), 32'd0);
    $display("txn cpu write addr=5 data=1234 gnt=%b", cpu_gnt);
    tick();
    drive(1'b1, 1'b0, 5'd5, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    check_val("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_val("rd_mem_we", 32'(mem_we), 32'd0);
    check_val("rd_write_no_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    tick();
    idle();
    check_val("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_val("rd_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    check_val("rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    check_val("idle_mem_en", 32'(mem_en), 32'd0);
    check_val("idle_mem_addr", 32'(mem_addr), 32'd0);
    $display("txn cpu read addr=5 rdata=%h", cpu_rdata);

    // Interleaved: CPU reads 3, then debug reads 31.
    tick();
    drive(1'b1, 1'b0, 5'd3, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    check_val("il_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd31, 16'h0);
    check_val("il_dbg_gnt", 32'(dbg_gnt), 32'd1);
    check_val("il_mem_addr31", 32'(mem_addr), 32'd31);
    check_val("il_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_val("il_cpu_rdata", 32'(cpu_rdata), 32'd3);
    check_val("il_dbg_rdata_n1", 32'({dbg_rvalid, dbg_rdata}), 32'd0);
    tick();
    idle();
    check_val("il_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    check_val("il_dbg_rdata", 32'(dbg_rdata), 32'd31);
    check_val("il_cpu_rdata_n2", 32'({cpu_rvalid, cpu_rdata}), 32'd0);
    $display("txn interleave cpu=3 dbg=%0d", dbg_rdata);

    // Debug write 0xBEEF to 7, then CPU reads 7.
    tick();
    drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b1, 5'd7, 16'hBEEF);
    check_val("dw_dbg_gnt", 32'(dbg_gnt), 32'd1);
    check_val("dw_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    drive(1'b1, 1'b0, 5'd7, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    check_val("dw_no_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check_val("dw_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    idle();
    check_val("dw_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    $display("txn dbg write 7 then cpu read=%h", cpu_rdata);

    // Contention: both read continuously; expect CPU x4 then debug, repeating.
    for (int k = 0; k < 10; k++) begin
      tick();
      drive(1'b1, 1'b0, 5'd1, 16'h0, 1'b1, 1'b0, 5'd2, 16'h0);
      check_val("ct_cpu_gnt", 32'(cpu_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
      check_val("ct_dbg_gnt", 32'(dbg_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check_val("ct_cpu_rdata", 32'(cpu_rdata), (k % 5 == 0) ? 32'd0 : 32'd1);
        check_val("ct_dbg_rdata", 32'(dbg_rdata), (k % 5 == 0) ? 32'd2 : 32'd0);
      end
      $display("txn contention %0d: cpu_gnt=%b dbg_gnt=%b", k, cpu_gnt, dbg_gnt);
    end
    tick();
    idle();
    check_val("ct_last_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    check_val("ct_last_dbg_rdata", 32'(dbg_rdata), 32'd2);

    // Reset during a read.
    tick();
    drive(1'b1, 1'b0, 5'd2, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    check_val("rr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 5'd2, 16'h0, 1'b1, 1'b0, 5'd3, 16'h0);
    check_val("rr_n1_rvalid", 32'(cpu_rvalid), 32'd1);
    check_val("rr_n1_rdata", 32'(cpu_rdata), 32'd2);
    check_val("rr_n1_mem_en", 32'(mem_en), 32'd0);
    check_val("rr_n1_gnts", 32'({cpu_gnt, dbg_gnt}), 32'd0);
    tick();
    check_val("rr_n2_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    check_val("rr_n2_mem_en", 32'(mem_en), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    check_val("rr_n3_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
    $display("txn reset during read: n3 rvalid=%b", cpu_rvalid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the 32 x 16-bit data memory of the Harvard processor. Shares the single memory port between the CPU load/store unit and the debug/loader port, issues one access per cycle, and routes the one-cycle-latency read data back to the requester that issued it. CPU has priority. A bounded-wait counter guarantees the debug port is granted under sustained CPU traffic.

## Interface
- `ADDR_W`, default 5: word address width (32 words).
- `DATA_W`, default 16: data word width.
- `MAX_WAIT`, default 4: maximum consecutive contested cycles the debug port loses before it is forced to win; legal range 1..15.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `cpu_req`  in  1: CPU access request; requester holds `cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_gnt`.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W: word address.
- `cpu_wdata`  in  DATA_W: write data.
- `cpu_gnt`  out  1: access accepted this cycle.
- `cpu_rvalid`  out  1: read data valid on `cpu_rdata`.
- `cpu_rdata`  out  DATA_W: read data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same directions, widths and meanings as the CPU port.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable, valid with `mem_en`.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data, valid the cycle after a read strobe (registered read).

## Operation
- Grant is combinational from the current requests and `wait_cnt`.
  - Only one requester: it wins.
  - Both requesting and `wait_cnt` < MAX_WAIT: CPU wins.
  - Both requesting and `wait_cnt` == MAX_WAIT: debug wins.
- `wait_cnt` (4 bits):
  - Increments when `dbg_req` = 1 and the debug port is not granted.
  - Clears when the debug port is granted, when `dbg_req` = 0, and on reset.
  - Saturates at MAX_WAIT.
- The winner's `we`/`addr`/`wdata` drive `mem_we`/`mem_addr`/`mem_wdata`, and `mem_en` = 1. With no winner: `mem_en` = 0, `mem_we` = 0, and `mem_addr`/`mem_wdata` = 0.
- Exactly one of `cpu_gnt`/`dbg_gnt` is high when `mem_en` = 1. Neither is high otherwise.
- Read tracking: the registered `rd_pending` (1 bit) and `rd_owner` (0 = CPU, 1 = debug) are loaded each cycle from (`mem_en` & ~`mem_we`, winner).
- Responses:
  - `cpu_rvalid` = `rd_pending` & (`rd_owner` == 0).
  - `dbg_rvalid` = `rd_pending` & (`rd_owner` == 1).
  - Each `rdata` output = `mem_rdata` when its own `rvalid` is high, else 0. Data never appears on the non-owner port.
- Writes produce no `rvalid`. The `gnt` cycle is the write's completion.
- Back-to-back accesses from either or both ports are allowed every cycle. Read responses return in issue order, one per cycle.
- Address handling: addresses are ADDR_W bits wide with no wrap logic. Address 31 is the last word.

## Timing
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle `req` is sampled high and wins.
- Read latency: `rvalid`/`rdata` arrive exactly 1 cycle after the granted read.
- Worst-case debug wait under continuous CPU requests: MAX_WAIT cycles. The debug port is granted on cycle MAX_WAIT+1, giving a steady MAX_WAIT:1 CPU:debug pattern.
- Reset values: `cpu_gnt`, `dbg_gnt`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0; `cpu_rvalid`, `dbg_rvalid` = 0; `cpu_rdata`, `dbg_rdata` = 0; `wait_cnt` = 0; `rd_pending` = 0.
- While `rst` = 1, all grants and `mem_en` are forced to 0, whatever the requests.
- Reset during operation:
  - A read granted in the cycle before `rst` rises still returns its `rvalid` in the first reset cycle.
  - No `rvalid` is produced in the cycle after any reset cycle.
- Simultaneous read by one port and write by the other: only the winner accesses memory. The loser keeps requesting and is served later.

## Test plan
- Reset with both ports requesting: `rst` = 1 for 2 cycles, `cpu_req` = `dbg_req` = 1. Both `gnt` = 0, `mem_en` = 0, both `rvalid` = 0 during reset and in the first cycle after it.
- CPU write then read: CPU writes 0x1234 to address 5, then reads address 5. `cpu_gnt` = 1 in both cycles, `cpu_rvalid` = 1 with `cpu_rdata` = 0x1234 one cycle after the read grant, and `dbg_rvalid` = 0 throughout.
- Sustained contention with MAX_WAIT = 4: both ports read continuously. Grants follow the pattern CPU, CPU, CPU, CPU, debug, repeating. `wait_cnt` reaches 4, then clears.
- Interleaved reads: CPU reads address 3 (mem = 3) in cycle n, debug reads address 31 (mem = 31) in cycle n+1. `cpu_rvalid` with 3 in cycle n+1, `dbg_rvalid` with 31 in cycle n+2, `cpu_rdata` = 0 in n+2.
- Debug write over CPU read: debug writes 0xBEEF to address 7 while CPU is idle, then CPU reads address 7. `cpu_rdata` = 0xBEEF, and the write produces no `rvalid`.
- Reset during a read: CPU read of address 2 granted in cycle n, `rst` = 1 in cycles n+1 and n+2. `cpu_rvalid` = 1 with data 2 in n+1, 0 in n+2 and n+3, and `mem_en` = 0 in n+1 and n+2.
